// File: rtl/tlul_mem_access_ctrl.sv
// TL-UL slave sequencing one single-port word memory access per request, no overlap; accept-to-D_VALID
// is 1 cycle for errors, 2 for Put, 3 for Get; A_READY stays low until the D handshake completes.
module tlul_mem_access_ctrl #(
  parameter int W        = 8,
  parameter int BYTE_BIT = 8,
  parameter int A        = 32,
  parameter int DEPTH    = 256,
  parameter int SRC_W    = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      a_valid_i,
  output logic                      a_ready_o,
  input  logic [2:0]                a_opcode_i,
  input  logic [A-1:0]              a_address_i,
  input  logic [W-1:0]              a_mask_i,
  input  logic [W*BYTE_BIT-1:0]     a_data_i,
  input  logic [SRC_W-1:0]          a_source_i,
  output logic                      d_valid_o,
  input  logic                      d_ready_i,
  output logic [2:0]                d_opcode_o,
  output logic [W*BYTE_BIT-1:0]     d_data_o,
  output logic                      d_error_o,
  output logic [SRC_W-1:0]          d_source_o,
  output logic [$clog2(DEPTH)-1:0]  mem_addr_o,
  output logic                      mem_re_o,
  output logic                      mem_we_o,
  output logic [W-1:0]              mem_wmask_o,
  output logic [W*BYTE_BIT-1:0]     mem_wdata_o,
  input  logic [W*BYTE_BIT-1:0]     mem_rdata_i
);

  localparam int OFF = $clog2(W);
  localparam int AW  = $clog2(DEPTH);
  localparam int DW  = W * BYTE_BIT;
  localparam int KW  = $clog2(W) + 1;

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

  state_e             state_q, state_d;
  logic               get_q, get_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [W-1:0]       mask_q, mask_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic               err_q, err_d;
  logic [2:0]         dop_q, dop_d;
  logic [DW-1:0]      ddata_q, ddata_d;

  logic [A-1:0]       word_idx;
  logic               is_get;
  logic               is_put;
  logic               req_err;
  logic               accept;
  logic [DW-1:0]      rdata_exp;
  logic [KW-1:0]      k;

  assign word_idx = a_address_i >> OFF;
  assign is_get   = (a_opcode_i == OP_GET);
  assign is_put   = (a_opcode_i == OP_PUT_FULL) || (a_opcode_i == OP_PUT_PART);
  assign accept   = a_valid_i && (state_q == IDLE);

  assign req_err = !(is_get || is_put)
                 || (a_address_i[OFF-1:0] != '0)
                 || (word_idx >= A'(DEPTH))
                 || ((a_opcode_i == OP_PUT_FULL) && (a_mask_i != '1))
                 || (a_mask_i == '0);

  // Memory returns the selected bytes packed from lane 0 upward; spread them onto the masked lanes.
  always_comb begin
    rdata_exp = '0;
    k         = '0;
    for (int i = 0; i < W; i++) begin
      if (mask_q[i]) begin
        rdata_exp[i*BYTE_BIT +: BYTE_BIT] = mem_rdata_i[k*BYTE_BIT +: BYTE_BIT];
        k = k + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    get_d   = get_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    src_d   = src_q;
    err_d   = err_q;
    dop_d   = dop_q;
    ddata_d = ddata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          get_d   = is_get;
          addr_d  = word_idx[AW-1:0];
          mask_d  = a_mask_i;
          wdata_d = a_data_i;
          src_d   = a_source_i;
          err_d   = req_err;
          dop_d   = is_get ? OP_ACK_DATA : OP_ACK;
          ddata_d = '0;
          state_d = req_err ? RESP : ISSUE;
        end
      end
      ISSUE:   state_d = get_q ? CAPTURE : RESP;
      CAPTURE: begin
        ddata_d = rdata_exp;
        state_d = RESP;
      end
      RESP:    if (d_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      get_q   <= 1'b0;
      addr_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      src_q   <= '0;
      err_q   <= 1'b0;
      dop_q   <= '0;
      ddata_q <= '0;
    end else begin
      state_q <= state_d;
      get_q   <= get_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      src_q   <= src_d;
      err_q   <= err_d;
      dop_q   <= dop_d;
      ddata_q <= ddata_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them in the same cycle.
  assign a_ready_o   = (state_q == IDLE);
  assign d_valid_o   = (state_q == RESP);
  assign mem_re_o    = (state_q == ISSUE) && get_q;
  assign mem_we_o    = (state_q == ISSUE) && !get_q;
  assign mem_addr_o  = addr_q;
  assign mem_wmask_o = mask_q;
  assign mem_wdata_o = wdata_q;
  assign d_opcode_o  = dop_q;
  assign d_data_o    = ddata_q;
  assign d_error_o   = err_q;
  assign d_source_o  = src_q;

endmodule

// File: tb/tb_tlul_mem_access_ctrl.sv
// Self-checking bench: directed TL-UL transactions plus random traffic against a word-level memory model.
module tb_tlul_mem_access_ctrl;
  localparam int W = 8, DEPTH = 256, SRC_W = 4, DW = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              a_valid, a_ready, d_valid, d_ready, d_error, mem_re, mem_we;
  logic [2:0]        a_opcode, d_opcode;
  logic [31:0]       a_address;
  logic [W-1:0]      a_mask, mem_wmask;
  logic [DW-1:0]     a_data, d_data, mem_wdata;
  logic [DW-1:0]     mem_rdata = '0;
  logic [SRC_W-1:0]  a_source, d_source;
  logic [7:0]        mem_addr;

  int tests = 0, fails = 0, cyc = 0;
  int prev_acc = 0, prev_gap = 0;
  bit b2b = 1'b0;
  logic mem_init = 1'b1;
  logic [DW-1:0] smem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  tlul_mem_access_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_opcode_i(a_opcode), .a_address_i(a_address),
    .a_mask_i(a_mask), .a_data_i(a_data), .a_source_i(a_source),
    .d_valid_o(d_valid), .d_ready_i(d_ready), .d_opcode_o(d_opcode), .d_data_o(d_data),
    .d_error_o(d_error), .d_source_o(d_source),
    .mem_addr_o(mem_addr), .mem_re_o(mem_re), .mem_we_o(mem_we), .mem_wmask_o(mem_wmask),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_word(input int i);
    return {32'(i) * 32'h9E3779B1, (32'(i) * 32'h85EBCA6B) ^ 32'hA5A5A5A5};
  endfunction

  // Memory stub: byte-enabled writes, registered reads.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) smem[i] <= init_word(i);
    end else if (mem_we) begin
      for (int b = 0; b < W; b++)
        if (mem_wmask[b]) smem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    if (mem_re) mem_rdata <= smem[mem_addr];
  end

  // Reference lane expansion: take word bytes in order, hand one to each enabled lane.
  function automatic logic [DW-1:0] ref_expand(input logic [DW-1:0] word, input logic [W-1:0] mask);
    logic [7:0] q[$];
    logic [DW-1:0] res;
    res = '0;
    for (int b = 0; b < W; b++) q.push_back(word[b*8 +: 8]);
    for (int l = 0; l < W; l++)
      if (mask[l]) res[l*8 +: 8] = q.pop_front();
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a negedge with the DUT idle.
  task automatic txn(input logic [2:0] op, input logic [31:0] addr, input logic [W-1:0] mask,
                     input logic [DW-1:0] data, input logic [SRC_W-1:0] src, input int hold,
                     output logic [DW-1:0] obs);
    logic err;
    int idx, lat, n, we_n, re_n, acc;
    logic [DW-1:0] exp_d;
    logic [2:0] exp_op;
    idx = int'(addr >> 3);
    err = (op != 3'd0 && op != 3'd1 && op != 3'd4) || (addr[2:0] != 3'd0) || (idx >= DEPTH)
          || (op == 3'd0 && mask != 8'hFF) || (mask == 8'h00);
    exp_op = (op == 3'd4) ? 3'd1 : 3'd0;
    exp_d  = '0;
    if (err)              lat = 1;
    else if (op == 3'd4) begin lat = 3; exp_d = ref_expand(ref_mem[idx], mask); end
    else                  lat = 2;

    chk("a_ready_idle", 64'(a_ready), 64'd1);
    a_valid = 1'b1; a_opcode = op; a_address = addr; a_mask = mask; a_data = data; a_source = src;
    d_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    if (b2b) chk("accept_spacing", 64'(acc - prev_acc), 64'(prev_gap));
    a_valid = 1'b0; a_opcode = 3'($urandom); a_address = $urandom; a_mask = 8'($urandom);
    a_data = {$urandom, $urandom}; a_source = 4'($urandom);

    n = 1; we_n = 0; re_n = 0;
    while (d_valid !== 1'b1 && n < 8) begin
      chk("a_ready_busy", 64'(a_ready), 64'd0);
      if (mem_we === 1'b1) begin
        we_n++;
        chk("we_addr", 64'(mem_addr), 64'(idx));
        chk("we_mask", 64'(mem_wmask), 64'(mask));
        chk("we_data", mem_wdata, data);
      end
      if (mem_re === 1'b1) begin
        re_n++;
        chk("re_addr", 64'(mem_addr), 64'(idx));
      end
      @(negedge clk);
      n++;
    end
    chk("d_valid_seen", 64'(d_valid), 64'd1);
    chk("latency", 64'(n), 64'(lat));
    chk("we_count", 64'(we_n), 64'((!err && op != 3'd4) ? 1 : 0));
    chk("re_count", 64'(re_n), 64'((!err && op == 3'd4) ? 1 : 0));
    obs = d_data;

    for (int h = 0; h <= hold; h++) begin
      chk("d_valid_hold", 64'(d_valid), 64'd1);
      chk("d_opcode", 64'(d_opcode), 64'(exp_op));
      chk("d_error", 64'(d_error), 64'(err));
      chk("d_source", 64'(d_source), 64'(src));
      chk("d_data", d_data, exp_d);
      if (h > 0) chk("a_ready_bp", 64'(a_ready), 64'd0);
      if (h == hold) d_ready = 1'b1;
      @(negedge clk);
    end
    chk("d_valid_done", 64'(d_valid), 64'd0);
    chk("a_ready_back", 64'(a_ready), 64'd1);

    if (!err && op != 3'd4)
      for (int b = 0; b < W; b++)
        if (mask[b]) ref_mem[idx][b*8 +: 8] = data[b*8 +: 8];
    prev_acc = acc; prev_gap = lat + hold + 1; b2b = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] obs;
    logic [2:0] op;
    logic [31:0] addr;
    logic [W-1:0] mask;
    int sel, widx;

    a_valid = 0; a_opcode = 0; a_address = 0; a_mask = 0; a_data = 0; a_source = 0; d_ready = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    repeat (3) @(negedge clk);
    chk("rst_a_ready", 64'(a_ready), 64'd1);
    chk("rst_d_valid", 64'(d_valid), 64'd0);
    chk("rst_mem_re", 64'(mem_re), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_d_data", d_data, 64'd0);
    chk("rst_d_meta", {58'd0, d_error, d_opcode, 2'b00}, 64'd0);
    chk("rst_d_source", 64'(d_source), 64'd0);
    mem_init = 1'b0; rst = 1'b0;
    @(negedge clk);

    // Directed: full write, full and sparse reads, partial write.
    txn(3'd0, 32'h10, 8'hFF, 64'h0807060504030201, 4'h3, 0, obs);
    txn(3'd4, 32'h10, 8'hFF, 64'h0, 4'h4, 0, obs);
    chk("get_full_readback", obs, 64'h0807060504030201);
    txn(3'd0, 32'h10, 8'hFF, 64'h1122334455_66BBAA, 4'h1, 0, obs);
    txn(3'd4, 32'h10, 8'h05, 64'h0, 4'h2, 0, obs);
    chk("get_mask05_lanes", obs, 64'h0000_0000_00BB_00AA);
    txn(3'd1, 32'h18, 8'h3C, 64'hFFEEDDCCBBAA9988, 4'h6, 0, obs);
    txn(3'd4, 32'h18, 8'hC3, 64'h0, 4'h6, 0, obs);
    // Errors, back to back at the minimum spacing.
    txn(3'd4, 32'h03, 8'hFF, 64'h0, 4'h9, 0, obs);
    txn(3'd0, 32'h18, 8'h0F, 64'h1234, 4'h8, 0, obs);
    txn(3'd2, 32'h18, 8'hFF, 64'h0, 4'h7, 0, obs);
    txn(3'd1, 32'h18, 8'h00, 64'h55, 4'h5, 0, obs);
    // Range limits.
    txn(3'd0, 32'h7F8, 8'hFF, 64'hCAFEF00D12345678, 4'hB, 0, obs);
    txn(3'd4, 32'h7F8, 8'hF0, 64'h0, 4'hC, 0, obs);
    txn(3'd4, 32'h800, 8'hFF, 64'h0, 4'hD, 0, obs);
    // Backpressure.
    txn(3'd4, 32'h10, 8'h81, 64'h0, 4'hA, 5, obs);
    txn(3'd0, 32'h20, 8'hFF, 64'h0123456789ABCDEF, 4'h5, 5, obs);
    txn(3'd2, 32'h20, 8'hFF, 64'h0, 4'hE, 3, obs);

    // Async reset during the strobe cycle.
    for (int r = 0; r < 2; r++) begin
      b2b = 1'b0;
      a_valid = 1'b1; a_opcode = (r == 0) ? 3'd0 : 3'd4; a_address = 32'h40; a_mask = 8'hFF;
      a_data = 64'hDEADBEEF00C0FFEE; a_source = 4'h7;
      @(posedge clk);
      @(negedge clk);
      a_valid = 1'b0;
      chk("rst_pre_strobe", 64'(r == 0 ? mem_we : mem_re), 64'd1);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_we", 64'(mem_we), 64'd0);
      chk("rst_mid_re", 64'(mem_re), 64'd0);
      chk("rst_mid_d_valid", 64'(d_valid), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_post_a_ready", 64'(a_ready), 64'd1);
      chk("rst_post_d_valid", 64'(d_valid), 64'd0);
    end
    txn(3'd4, 32'h40, 8'hFF, 64'h0, 4'h1, 0, obs);

    // Random traffic.
    for (int r = 0; r < 60; r++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)      op = 3'd4;
      else if (sel < 6) op = 3'd0;
      else if (sel < 8) op = 3'd1;
      else              op = 3'($urandom_range(0, 7));
      widx = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH - 1, DEPTH + 2) : $urandom_range(0, 15);
      addr = 32'(widx) << 3;
      if ($urandom_range(0, 9) == 0) addr[2:0] = 3'($urandom_range(1, 7));
      mask = (op == 3'd0 && $urandom_range(0, 7) != 0) ? 8'hFF : 8'($urandom);
      txn(op, addr, mask, {$urandom, $urandom}, 4'($urandom), $urandom_range(0, 3), obs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
